// File: rtl/fixed_divider_display.sv
// Waits a fixed number of cycles after the divider start strobe, captures the quotient,
// and scans one 16-bit page of it onto a 4-digit multiplexed 7-segment display.
module fixed_divider_display #(
   parameter int unsigned WAIT_CYCLES   = 33,
   parameter int unsigned PRESCALE_BITS = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        init,
   input  logic [31:0] result,
   input  logic        page,
   input  logic        blank_lz,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic        valid,
   output logic        busy
);

   localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES - 1);
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SHOW = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [31:0]              hold_q, hold_d;
   logic [PRESCALE_BITS-1:0] pre_q, pre_d;
   logic [1:0]               idx_q, idx_d;

   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         hold_q  <= '0;
         pre_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hold_q  <= hold_d;
         pre_q   <= pre_d;
         idx_q   <= idx_d;
      end
   end

   // init wins in every state, so a strobe during WAIT simply restarts the count
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold_d  = hold_q;
      if (init) begin
         state_d = ST_WAIT;
         cnt_d   = WAIT_LOAD;
      end else if (state_q == ST_WAIT) begin
         if (cnt_q == '0) begin
            hold_d  = result;
            state_d = ST_SHOW;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   always_comb begin
      pre_d = pre_q + 1'b1;
      idx_d = (pre_q == '1) ? idx_q + 2'd1 : idx_q;
   end

   logic [15:0] page_w;
   logic [3:0]  nib;
   logic        lz;

   always_comb begin
      page_w = page ? hold_q[31:16] : hold_q[15:0];
      nib    = '0;
      lz     = 1'b0;
      case (idx_q)
         2'd0: nib = page_w[3:0];
         2'd1: begin nib = page_w[7:4];   lz = (page_w[15:4]  == '0); end
         2'd2: begin nib = page_w[11:8];  lz = (page_w[15:8]  == '0); end
         default: begin nib = page_w[15:12]; lz = (page_w[15:12] == '0); end
      endcase
   end

   always_comb begin
      an    = ~(4'b0001 << idx_q);
      valid = (state_q == ST_SHOW);
      busy  = (state_q == ST_WAIT);
      dp    = ~((idx_q == 2'd0) && (state_q == ST_SHOW) && page);
      if (state_q != ST_SHOW)
         seg = SEG_DASH;
      else if (blank_lz && lz)
         seg = SEG_BLANK;
      else
         seg = hex_seg(nib);
   end

endmodule

// File: doc/fixed_divider_display.md
FIXED_DIVIDER_DISPLAY -- requirements
Module: fixed_divider_display

Interface
REQ-001 Parameter WAIT_CYCLES, default 33: clock edges from the last init-high edge to result capture.
REQ-002 Parameter PRESCALE_BITS, default 16: width of the digit-scan prescaler.
REQ-003 Port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port init, input, 1: divider start strobe, shared with the upstream fixed_divider.
REQ-006 Port result, input, 32: fixed_divider quotient bus.
REQ-007 Port page, input, 1: 0 selects result[15:0], 1 selects result[31:16] for display.
REQ-008 Port blank_lz, input, 1: 1 enables leading-zero blanking.
REQ-009 Port an, output, 4: digit anodes, active-low, one-hot-low.
REQ-010 Port seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-011 Port dp, output, 1: decimal point, active-low.
REQ-012 Port valid, output, 1: captured result is displayed.
REQ-013 Port busy, output, 1: waiting for the divider.

Function
REQ-014 FSM states: IDLE, WAIT, SHOW; busy=1 only in WAIT; valid=1 only in SHOW.
REQ-015 Any edge sampling init=1, in any state: go to WAIT, load wait counter with WAIT_CYCLES-1.
REQ-016 WAIT, init=0, counter>0: decrement counter.
REQ-017 WAIT, init=0, counter=0: capture result into a 32-bit hold register, go to SHOW.
REQ-018 Capture timing: exactly WAIT_CYCLES edges after the last edge that sampled init=1.
REQ-019 SHOW holds the capture until the next init; result changes in SHOW are ignored.
REQ-020 Prescaler: PRESCALE_BITS-bit free-running up-counter, active in all states.
REQ-021 Digit index: 2-bit, increments mod 4 on the edge where the prescaler wraps from all-ones to zero.
REQ-022 Digit 0 is leftmost-free: an[i]=0 exactly when index=i, all others 1.
REQ-023 Digit i displays nibble i of the selected 16-bit page of the hold register.
REQ-024 Hex encoding, active-low: 0=1000000, 1=1111001, 8=0000000, A=0001000, F=0001110; the remaining digits use standard 7-segment patterns.
REQ-025 Leading-zero blanking: with blank_lz=1, digit i (i=1..3) has seg=1111111 if nibbles i..3 of the page are all zero; digit 0 is never blanked.
REQ-026 dp=0 only when index=0, state=SHOW and page=1; otherwise dp=1.
REQ-027 In IDLE and WAIT, every digit shows a dash: seg=0111111; anode scanning continues.
REQ-028 an, seg and dp are combinational from registered state plus the page and blank_lz inputs; a page change takes effect in the same cycle.
REQ-029 An init during WAIT restarts the count; no partial capture occurs.

Reset
REQ-030 reset=1 forces the following immediately, independent of clock: state=IDLE, wait counter=0, hold=0, prescaler=0, index=0.
REQ-031 Output values during reset: an=1110, seg=0111111, dp=1, valid=0, busy=0.
REQ-032 Reset during WAIT aborts the capture; hold stays 0 until a complete new init/WAIT sequence.
REQ-033 Release of reset: the first rising edge after deassertion behaves as normal operation from the IDLE state.

Verification (PRESCALE_BITS=2, WAIT_CYCLES=4)
REQ-034 Stimulus: reset, then idle for 16 cycles. Required: seg=0111111 throughout; an cycles 1110, 1101, 1011, 0111, each for 4 cycles; valid=0.
REQ-035 Stimulus: init pulse of 1 cycle, result=0x1234ABCD, page=0. Required: busy=1 for 4 edges, then valid=1; digits 0..3 show D, C, B, A; dp=1.
REQ-036 Stimulus: same capture, page=1, blank_lz=0. Required: digits show 4, 3, 2, 1; dp=0 on digit 0 only.
REQ-037 Stimulus: result=0x00000008, page=0, blank_lz=1. Required: digit 0=0000000; digits 1-3 seg=1111111; with blank_lz=0, digits 1-3=1000000.
REQ-038 Stimulus: init held high for 3 cycles, then a second init 2 cycles into WAIT. Required: capture occurs 4 edges after the last init edge; result changes after capture do not alter the display.
REQ-039 Stimulus: reset asserted mid-WAIT, between edges. Required: outputs reach their reset values with no clock edge; valid never asserts.
